selftrigger_frame_builder: RTL
==============================

# selftrigger_frame_builder

Downstream consumer of the HPF/pedestal-recovery self-trigger stage. Continuously stores the filtered waveform `y` in a ring buffer. On each accepted `trigger_output` pulse it emits one frame on a 16-bit valid/ready stream:
- a header: timestamp and baseline;
- PRE_SAMPLES samples from before the trigger;
- the samples after the trigger, up to FRAME_SAMPLES in total.

It feeds the channel readout/spy path.

## Interface
- PRE_SAMPLES, 64, samples preceding the trigger cycle included in the frame (1..FRAME_SAMPLES-1)
- FRAME_SAMPLES, 256, total waveform samples per frame
- ADDR_W, 10, ring depth = 2**ADDR_W; must satisfy 2**ADDR_W ≥ 2·FRAME_SAMPLES
- clk  in  1  sample clock; one sample per cycle
- reset  in  1  synchronous, active-high
- enable  in  1  arms triggering; ring writes continue regardless
- din  in  16 signed  filtered waveform (`y` of the trigger stage)
- baseline  in  16 signed  pedestal estimate
- trigger  in  1  single-cycle trigger pulse
- timestamp  in  64  free-running timestamp, same domain
- out_data  out  16  frame word
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_sof  out  1  first header word of a frame
- out_last  out  1  final word of a frame
- busy  out  1  frame in progress
- missed_count  out  16  triggers dropped, saturating
- overrun_count  out  16  frames whose readout fell ≥ 2**ADDR_W−1 behind the write pointer, saturating

## Operation
- Ring write:
  - every cycle not in reset: `ram[wptr] <= din`, then `wptr++` (wraps mod 2**ADDR_W).
  - `fill` counts written samples and saturates at PRE_SAMPLES.
- Armed when `enable` and `fill == PRE_SAMPLES`.
- A trigger accepted in IDLE while armed:
  - latch `start = wptr − PRE_SAMPLES` (mod depth); the trigger-cycle sample is index PRE_SAMPLES of the frame;
  - latch `timestamp` and `baseline`;
  - go to HDR.
- Trigger while not armed in IDLE: ignored, no count.
- Trigger while busy (any state ≠ IDLE): `missed_count++`.
- States: IDLE → HDR → DATA → (TRL) → IDLE.
  - HDR: 5 words, in order ts[63:48], ts[47:32], ts[31:16], ts[15:0], baseline. `out_sof` on word 0.
  - DATA: FRAME_SAMPLES words read from `start`, `start+1`, … A read address is issued only when it is not equal to `wptr` (the sample has been written). `out_last` on the final sample unless FRAME_CHECKSUM_EN.
  - TRL: see Configuration.
- Backpressure: words are never dropped or duplicated. `out_data` and `out_sof`/`out_last` hold stable while `out_valid & !out_ready`.
- Overrun: if `wptr − rd_addr` (mod depth) reaches 2**ADDR_W−1 during DATA:
  - increment `overrun_count` once per frame;
  - the frame still completes at full length, and its content is undefined from that point.
- Reset mid-frame:
  - next cycle `out_valid=0`; no `out_last`;
  - state IDLE, `fill=0`, `wptr=0`, counters=0.
- Reset values: `out_data=0`, `out_valid=0`, `out_sof=0`, `out_last=0`, `busy=0`, `missed_count=0`, `overrun_count=0`.

## Timing
- Trigger accepted at cycle T: `busy=1` and first header word `out_valid=1` at T+1.
- RAM read latency: 1 cycle. A 2-entry output skid register hides it, giving one word per cycle when `out_ready` is held high.
- Frame with `out_ready` held high: 5 + FRAME_SAMPLES (+1) consecutive valid cycles.
- With `out_ready` held high, the DATA read pointer stalls on the write pointer. Post-trigger samples are therefore emitted at the sample rate, about 1 word per cycle behind the write.
- After `out_last` is accepted at cycle L: IDLE at L+1. A trigger at L+1 is accepted.
- Trigger on the same cycle as `out_last` acceptance counts as missed.

## Configuration
- `SELFTRIG_FRAME_CHECKSUM_EN` defined:
  - TRL state appends one word = XOR of all header and sample words of the frame;
  - `out_last` is on that word;
  - frame length is 6 + FRAME_SAMPLES.
- Not defined: no TRL state; frame length is 5 + FRAME_SAMPLES.

## Structure
- Package `daphne_selftrig_pkg`:
  - state enum (IDLE/HDR/DATA/TRL);
  - HDR_WORDS=5;
  - default PRE_SAMPLES/FRAME_SAMPLES/ADDR_W;
  - the saturating-counter width (16).
- Sub-module `selftrig_ring_ram`: simple dual-port RAM, 2**ADDR_W × 16, one write port, one registered read port, inferable as BRAM.

## Test plan
- Ramp: `din = cycle index` from reset, `out_ready=1`, trigger at cycle 500 → header carries the latched ts/baseline; samples 436..691 in order; `out_last` on word 260; `missed_count=0`.
- Not-armed trigger: trigger at cycle 10 with PRE_SAMPLES=64 → no frame, `missed_count=0`. A trigger at cycle 100 → frame starting at sample 36.
- Busy trigger: triggers at 500 and 520 → one frame, `missed_count=1`. Trigger at the `out_last`-accept cycle → `missed_count=2`.
- Backpressure: `out_ready` toggles with a random 50% duty → the word sequence is identical to the ramp case, and held words are stable under stall.
- Overrun with ADDR_W=9: `out_ready=0` for 600 cycles mid-DATA → `overrun_count=1`, frame length still 261; `busy` clears after `out_last`.
- `SELFTRIG_FRAME_CHECKSUM_EN` defined, ramp case → 262 words, the last equals the XOR of the preceding 261. Reset asserted at header word 2 → `out_valid=0` the next cycle, and all counters read 0.

Source files
------------

// File: rtl/daphne_selftrig_pkg.sv
// Shared types and defaults for the self-trigger frame builder.
package daphne_selftrig_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2,
      ST_TRL  = 2'd3
   } st_e;

   localparam int unsigned HDR_WORDS         = 5;
   localparam int unsigned DEF_PRE_SAMPLES   = 64;
   localparam int unsigned DEF_FRAME_SAMPLES = 256;
   localparam int unsigned DEF_ADDR_W        = 10;
   localparam int unsigned CNT_W             = 16;
   localparam int unsigned WORD_W            = 16;

   // One stream word with its framing flags.
   typedef struct packed {
      logic              sof;
      logic              last;
      logic [WORD_W-1:0] data;
   } fword_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/selftrig_ring_ram.sv
// Simple dual-port ring RAM: one write port, one registered read port.
module selftrig_ring_ram #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [0:(1 << ADDR_W)-1];
   logic [DATA_W-1:0] rd_q;

   // Write and registered read, no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rd_q <= mem_q[raddr_i];
   end

   assign rdata_o = rd_q;

endmodule

// File: rtl/selftrigger_frame_builder.sv
// Ring-buffers the filtered waveform and emits one header+samples frame per
// accepted trigger on a 16-bit valid/ready stream.
// Optional trailer checksum word: define SELFTRIG_FRAME_CHECKSUM_EN.
module selftrigger_frame_builder
   import daphne_selftrig_pkg::*;
#(
   parameter int unsigned PRE_SAMPLES   = DEF_PRE_SAMPLES,
   parameter int unsigned FRAME_SAMPLES = DEF_FRAME_SAMPLES,
   parameter int unsigned ADDR_W        = DEF_ADDR_W
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] din,
   input  logic [15:0] baseline,
   input  logic        trigger,
   input  logic [63:0] timestamp,
   output logic [15:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_sof,
   output logic        out_last,
   output logic        busy,
   output logic [15:0] missed_count,
   output logic [15:0] overrun_count
);

   localparam int unsigned PCNT_W = $clog2(PRE_SAMPLES + 1);
   localparam int unsigned FCNT_W = $clog2(FRAME_SAMPLES + 1);

   st_e               state_q;
   logic [ADDR_W-1:0] wptr_q;
   logic [PCNT_W-1:0] fill_q;
   logic              busy_q;
   logic [2:0]        hdr_idx_q;
   logic [31:0]       ts_lo_q;
   logic [15:0]       bl_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [FCNT_W-1:0] rd_cnt_q;
   logic              ovr_seen_q;
   logic              pend_valid_q;
   logic              pend_ram_q;
   logic              pend_last_q;
   logic [15:0]       pend_word_q;
   fword_t            out_q;
   logic              out_valid_q;
   fword_t            skid_q;
   logic              skid_valid_q;
   logic [CNT_W-1:0]  missed_q;
   logic [CNT_W-1:0]  overrun_q;
`ifdef SELFTRIG_FRAME_CHECKSUM_EN
   logic              pend_trl_q;
   logic              trl_sent_q;
   logic [15:0]       csum_q;
`endif

   logic [15:0]       ram_rdata;
   logic              pop_c;
   logic [1:0]        committed_c;
   logic              can_issue_c;
   logic              accept_c;
   logic              issue_rd_c;
   logic              push_c;
   fword_t            push_w;
   logic [15:0]       hdr_word_c;
   logic [ADDR_W-1:0] lag_c;

   selftrig_ring_ram #(.ADDR_W(ADDR_W), .DATA_W(16)) u_ram (
      .clk     (clk),
      .we_i    (!reset),
      .waddr_i (wptr_q),
      .wdata_i (din),
      .re_i    (issue_rd_c),
      .raddr_i (rd_addr_q),
      .rdata_o (ram_rdata)
   );

   // Credit accounting, trigger acceptance, and the word entering the output queue.
   always_comb begin
      pop_c       = out_valid_q & out_ready;
      committed_c = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(pend_valid_q) - 2'(pop_c);
      can_issue_c = committed_c < 2'd2;
      accept_c    = (state_q == ST_IDLE) && trigger && enable &&
                    (fill_q == PCNT_W'(PRE_SAMPLES));
      issue_rd_c  = (state_q == ST_DATA) && (rd_cnt_q != FCNT_W'(FRAME_SAMPLES)) &&
                    can_issue_c && (rd_addr_q != wptr_q);
      lag_c       = wptr_q - rd_addr_q;
      case (hdr_idx_q)
         3'd2:    hdr_word_c = ts_lo_q[31:16];
         3'd3:    hdr_word_c = ts_lo_q[15:0];
         default: hdr_word_c = bl_q;
      endcase
      push_c = 1'b0;
      push_w = '0;
      if (accept_c) begin
         push_c      = 1'b1;
         push_w.sof  = 1'b1;
         push_w.data = timestamp[63:48];
      end else if (pend_valid_q) begin
         push_c      = 1'b1;
         push_w.last = pend_last_q;
         push_w.data = pend_ram_q ? ram_rdata : pend_word_q;
`ifdef SELFTRIG_FRAME_CHECKSUM_EN
         if (pend_trl_q) push_w.data = csum_q;
`endif
      end
   end

   // Ring write pointer, frame FSM, issue stage, 2-entry output queue and counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         wptr_q       <= '0;
         fill_q       <= '0;
         busy_q       <= 1'b0;
         hdr_idx_q    <= '0;
         ts_lo_q      <= '0;
         bl_q         <= '0;
         rd_addr_q    <= '0;
         rd_cnt_q     <= '0;
         ovr_seen_q   <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_ram_q   <= 1'b0;
         pend_last_q  <= 1'b0;
         pend_word_q  <= '0;
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         missed_q     <= '0;
         overrun_q    <= '0;
`ifdef SELFTRIG_FRAME_CHECKSUM_EN
         pend_trl_q   <= 1'b0;
         trl_sent_q   <= 1'b0;
         csum_q       <= '0;
`endif
      end else begin
         wptr_q <= wptr_q + ADDR_W'(1);
         if (fill_q != PCNT_W'(PRE_SAMPLES)) fill_q <= fill_q + PCNT_W'(1);

         pend_valid_q <= 1'b0;
         pend_ram_q   <= 1'b0;
         pend_last_q  <= 1'b0;
`ifdef SELFTRIG_FRAME_CHECKSUM_EN
         pend_trl_q   <= 1'b0;
         if (push_c) csum_q <= (push_w.sof ? 16'h0000 : csum_q) ^ push_w.data;
`endif

         // output queue: head is the output register, skid absorbs the in-flight word
         if (pop_c || !out_valid_q) begin
            if (skid_valid_q) begin
               out_q        <= skid_q;
               out_valid_q  <= 1'b1;
               skid_q       <= push_w;
               skid_valid_q <= push_c;
            end else begin
               out_valid_q <= push_c;
               if (push_c) begin
                  out_q <= push_w;
               end else begin
                  out_q.sof  <= 1'b0;
                  out_q.last <= 1'b0;
               end
            end
         end else if (push_c) begin
            skid_q       <= push_w;
            skid_valid_q <= 1'b1;
         end

         if (trigger && (state_q != ST_IDLE)) missed_q <= sat_inc(missed_q);

         if ((state_q == ST_DATA) && (rd_cnt_q != FCNT_W'(FRAME_SAMPLES)) &&
             !ovr_seen_q && (lag_c == '1)) begin
            ovr_seen_q <= 1'b1;
            overrun_q  <= sat_inc(overrun_q);
         end

         case (state_q)
            ST_IDLE: begin
               if (accept_c) begin
                  ts_lo_q      <= timestamp[31:0];
                  bl_q         <= baseline;
                  rd_addr_q    <= wptr_q - ADDR_W'(PRE_SAMPLES);
                  rd_cnt_q     <= '0;
                  ovr_seen_q   <= 1'b0;
                  hdr_idx_q    <= 3'd2;
                  pend_valid_q <= 1'b1;
                  pend_word_q  <= timestamp[47:32];
                  busy_q       <= 1'b1;
                  state_q      <= ST_HDR;
`ifdef SELFTRIG_FRAME_CHECKSUM_EN
                  trl_sent_q   <= 1'b0;
`endif
               end
            end
            ST_HDR: begin
               if (can_issue_c) begin
                  pend_valid_q <= 1'b1;
                  pend_word_q  <= hdr_word_c;
                  hdr_idx_q    <= hdr_idx_q + 3'd1;
                  if (hdr_idx_q == 3'(HDR_WORDS - 1)) state_q <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (issue_rd_c) begin
                  pend_valid_q <= 1'b1;
                  pend_ram_q   <= 1'b1;
                  rd_addr_q    <= rd_addr_q + ADDR_W'(1);
                  rd_cnt_q     <= rd_cnt_q + FCNT_W'(1);
                  if (rd_cnt_q == FCNT_W'(FRAME_SAMPLES - 1)) begin
`ifdef SELFTRIG_FRAME_CHECKSUM_EN
                     state_q <= ST_TRL;
`else
                     pend_last_q <= 1'b1;
`endif
                  end
               end
               if (pop_c && out_q.last) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
`ifdef SELFTRIG_FRAME_CHECKSUM_EN
            ST_TRL: begin
               if (!trl_sent_q && can_issue_c) begin
                  pend_valid_q <= 1'b1;
                  pend_trl_q   <= 1'b1;
                  pend_last_q  <= 1'b1;
                  trl_sent_q   <= 1'b1;
               end
               if (pop_c && out_q.last) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
`endif
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign out_data      = out_q.data;
   assign out_sof       = out_q.sof;
   assign out_last      = out_q.last;
   assign out_valid     = out_valid_q;
   assign busy          = busy_q;
   assign missed_count  = missed_q;
   assign overrun_count = overrun_q;

endmodule
